// File: rtl/alu_issue_stage_pkg.sv
// rtl/alu_issue_stage_pkg.sv - ALU opcode, aluOp class and issue entry types.
package ControlSignals;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3
  } Alu_Operation_t;

  localparam logic [1:0] ALUOP_MEM    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;

  typedef struct packed {
    logic [63:0]    op1;
    logic [63:0]    op2;
    Alu_Operation_t opcode;
    logic           illegal;
  } issue_entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } issue_state_t;

  localparam issue_entry_t ENTRY_RESET = '{op1: 64'd0, op2: 64'd0, opcode: OP_ADD, illegal: 1'b0};

endpackage

// File: rtl/alu_issue_stage_decoder.sv
// rtl/alu_issue_stage_decoder.sv - combinational aluOp/funct to ALU opcode decode.
module alu_op_decoder
  import ControlSignals::*;
(
  input  logic [1:0]     aluOp_in,
  input  logic [2:0]     funct3_in,
  input  logic           funct7b5_in,
  output Alu_Operation_t opcode_out,
  output logic           illegal_out
);

  always_comb begin
    opcode_out  = OP_ADD;
    illegal_out = 1'b0;
    case (aluOp_in)
      ALUOP_MEM:    opcode_out = OP_ADD;
      ALUOP_BRANCH: opcode_out = OP_SUB;
      default: begin
        // funct7b5 only selects SUB for R-type; I-type ADDI ignores it
        case (funct3_in)
          F3_ADD:  opcode_out = (aluOp_in == ALUOP_RTYPE && funct7b5_in) ? OP_SUB : OP_ADD;
          F3_AND:  opcode_out = OP_AND;
          F3_OR:   opcode_out = OP_OR;
          default: illegal_out = 1'b1;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - two-entry skid issue stage feeding the ALU.
module alu_issue_stage
  import ControlSignals::*;
(
  input  logic           clk_in,
  input  logic           reset_in,
  input  logic           flush_in,
  input  logic           valid_in,
  output logic           ready_out,
  input  logic [63:0]    rs1Data_in,
  input  logic [63:0]    rs2Data_in,
  input  logic [63:0]    imm_in,
  input  logic           aluSrc_in,
  input  logic [1:0]     aluOp_in,
  input  logic [2:0]     funct3_in,
  input  logic           funct7b5_in,
  output logic [63:0]    operand1_out,
  output logic [63:0]    operand2_out,
  output Alu_Operation_t aluOpcode_out,
  output logic           valid_out,
  input  logic           ready_in,
  output logic           illegal_out
);

  issue_state_t   r_state;
  issue_entry_t   r_main;
  issue_entry_t   r_skid;
  logic           r_ready;
  logic           r_valid;

  Alu_Operation_t w_opcode;
  logic           w_illegal;
  issue_entry_t   w_new;
  logic           w_accept;
  logic           w_drain;

  alu_op_decoder u_decoder (
    .aluOp_in    (aluOp_in),
    .funct3_in   (funct3_in),
    .funct7b5_in (funct7b5_in),
    .opcode_out  (w_opcode),
    .illegal_out (w_illegal)
  );

  assign w_new = '{op1:     rs1Data_in,
                   op2:     aluSrc_in ? imm_in : rs2Data_in,
                   opcode:  w_opcode,
                   illegal: w_illegal};

  assign w_accept = valid_in & r_ready;
  assign w_drain  = r_valid & ready_in;

  always_ff @(posedge clk_in) begin
    if (reset_in || flush_in) begin
      r_state <= ST_EMPTY;
      r_main  <= ENTRY_RESET;
      r_skid  <= ENTRY_RESET;
      r_ready <= 1'b1;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_main  <= w_new;
            r_state <= ST_ONE;
            r_valid <= 1'b1;
          end
        end
        ST_ONE: begin
          if (w_accept && !w_drain) begin
            r_skid  <= w_new;
            r_state <= ST_TWO;
            r_ready <= 1'b0;
          end else if (w_drain && !w_accept) begin
            r_state <= ST_EMPTY;
            r_valid <= 1'b0;
          end else if (w_accept && w_drain) begin
            r_main <= w_new;
          end
        end
        ST_TWO: begin
          // ready is low here, so only a drain can move the state
          if (w_drain) begin
            r_main  <= r_skid;
            r_state <= ST_ONE;
            r_ready <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_EMPTY;
          r_ready <= 1'b1;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign ready_out     = r_ready;
  assign valid_out     = r_valid;
  assign operand1_out  = r_main.op1;
  assign operand2_out  = r_main.op2;
  assign aluOpcode_out = r_main.opcode;
  assign illegal_out   = r_main.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - self-checking bench for alu_issue_stage.
module tb_alu_issue_stage;
  import ControlSignals::*;

  logic           clk_in = 1'b0;
  logic           reset_in, flush_in, valid_in, ready_in;
  logic [63:0]    rs1Data_in, rs2Data_in, imm_in;
  logic           aluSrc_in, funct7b5_in;
  logic [1:0]     aluOp_in;
  logic [2:0]     funct3_in;
  logic           ready_out, valid_out, illegal_out;
  logic [63:0]    operand1_out, operand2_out;
  Alu_Operation_t aluOpcode_out;

  always #5 clk_in = ~clk_in;

  alu_issue_stage dut (
    .clk_in        (clk_in),
    .reset_in      (reset_in),
    .flush_in      (flush_in),
    .valid_in      (valid_in),
    .ready_out     (ready_out),
    .rs1Data_in    (rs1Data_in),
    .rs2Data_in    (rs2Data_in),
    .imm_in        (imm_in),
    .aluSrc_in     (aluSrc_in),
    .aluOp_in      (aluOp_in),
    .funct3_in     (funct3_in),
    .funct7b5_in   (funct7b5_in),
    .operand1_out  (operand1_out),
    .operand2_out  (operand2_out),
    .aluOpcode_out (aluOpcode_out),
    .valid_out     (valid_out),
    .ready_in      (ready_in),
    .illegal_out   (illegal_out)
  );

  typedef struct {
    logic [63:0]    op1;
    logic [63:0]    op2;
    Alu_Operation_t opcode;
    logic           illegal;
  } exp_t;

  typedef struct {
    logic [1:0]     aluop;
    logic [2:0]     f3;
    logic           f7;
    logic           src;
    Alu_Operation_t eop;
    logic           eill;
  } vec_t;

  exp_t sb[$];
  exp_t cur_exp;
  vec_t vecs[14];
  logic last_accept;
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic drive(input logic [1:0] aluop, input logic [2:0] f3, input logic f7,
                       input logic src, input logic [63:0] rs1, input logic [63:0] rs2,
                       input logic [63:0] imm, input Alu_Operation_t eop, input logic eill);
    valid_in    = 1'b1;
    aluOp_in    = aluop;
    funct3_in   = f3;
    funct7b5_in = f7;
    aluSrc_in   = src;
    rs1Data_in  = rs1;
    rs2Data_in  = rs2;
    imm_in      = imm;
    cur_exp.op1     = rs1;
    cur_exp.op2     = src ? imm : rs2;
    cur_exp.opcode  = eop;
    cur_exp.illegal = eill;
  endtask

  // Inputs are set just after a negedge; handshake is judged here, before the posedge.
  task automatic tick();
    exp_t e;
    #1;
    last_accept = 1'b0;
    if (reset_in || flush_in) begin
      sb.delete();
    end else begin
      if (valid_out && ready_in) begin
        check("sb_has_entry", 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("sb_op1", operand1_out, e.op1);
          check("sb_op2", operand2_out, e.op2);
          check("sb_opcode", 64'(aluOpcode_out), 64'(e.opcode));
          check("sb_illegal", 64'(illegal_out), 64'(e.illegal));
        end
      end
      if (valid_in && ready_out) begin
        sb.push_back(cur_exp);
        last_accept = 1'b1;
      end
    end
    @(negedge clk_in);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_valid"}, 64'(valid_out), 64'd0);
    check({tag, "_ready"}, 64'(ready_out), 64'd1);
    check({tag, "_illegal"}, 64'(illegal_out), 64'd0);
    check({tag, "_opcode"}, 64'(aluOpcode_out), 64'(OP_ADD));
    check({tag, "_op1"}, operand1_out, 64'd0);
    check({tag, "_op2"}, operand2_out, 64'd0);
  endtask

  task automatic drain_all(input string tag);
    int n;
    valid_in = 1'b0;
    ready_in = 1'b1;
    n = 0;
    while (sb.size() > 0 && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_drained"}, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    reset_in = 1'b1; flush_in = 1'b0; valid_in = 1'b0; ready_in = 1'b0;
    rs1Data_in = '0; rs2Data_in = '0; imm_in = '0;
    aluSrc_in = 1'b0; aluOp_in = 2'b00; funct3_in = 3'b000; funct7b5_in = 1'b0;
    cur_exp = '{64'd0, 64'd0, OP_ADD, 1'b0};
    last_accept = 1'b0;
    repeat (2) @(negedge clk_in);
    reset_in = 1'b0;
    check_reset("reset");

    vecs[0]  = '{2'b00, 3'b000, 1'b0, 1'b0, OP_ADD, 1'b0};
    vecs[1]  = '{2'b00, 3'b101, 1'b1, 1'b1, OP_ADD, 1'b0};
    vecs[2]  = '{2'b01, 3'b111, 1'b0, 1'b0, OP_SUB, 1'b0};
    vecs[3]  = '{2'b10, 3'b000, 1'b0, 1'b0, OP_ADD, 1'b0};
    vecs[4]  = '{2'b10, 3'b000, 1'b1, 1'b0, OP_SUB, 1'b0};
    vecs[5]  = '{2'b10, 3'b111, 1'b0, 1'b0, OP_AND, 1'b0};
    vecs[6]  = '{2'b10, 3'b110, 1'b1, 1'b0, OP_OR,  1'b0};
    vecs[7]  = '{2'b11, 3'b000, 1'b1, 1'b1, OP_ADD, 1'b0};
    vecs[8]  = '{2'b11, 3'b111, 1'b0, 1'b1, OP_AND, 1'b0};
    vecs[9]  = '{2'b11, 3'b110, 1'b0, 1'b1, OP_OR,  1'b0};
    vecs[10] = '{2'b10, 3'b001, 1'b0, 1'b0, OP_ADD, 1'b1};
    vecs[11] = '{2'b11, 3'b010, 1'b1, 1'b1, OP_ADD, 1'b1};
    vecs[12] = '{2'b10, 3'b101, 1'b1, 1'b0, OP_ADD, 1'b1};
    vecs[13] = '{2'b11, 3'b100, 1'b0, 1'b1, OP_ADD, 1'b1};

    // Table stream with random backpressure; the scoreboard checks every drained entry.
    for (int i = 0; i < 14; i++) begin
      int n;
      drive(vecs[i].aluop, vecs[i].f3, vecs[i].f7, vecs[i].src,
            {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
            vecs[i].eop, vecs[i].eill);
      n = 0;
      do begin
        ready_in = 1'($urandom_range(0, 1));
        tick();
        n++;
      end while (!last_accept && n < 30);
      check("vec_accepted", 64'(last_accept), 64'd1);
    end
    drain_all("vec");

    // R-type SUB: one-cycle latency
    ready_in = 1'b1;
    drive(2'b10, 3'b000, 1'b1, 1'b0, 64'd10, 64'd3, 64'd0, OP_SUB, 1'b0);
    tick();
    valid_in = 1'b0;
    check("sub_valid", 64'(valid_out), 64'd1);
    check("sub_opcode", 64'(aluOpcode_out), 64'(OP_SUB));
    check("sub_op1", operand1_out, 64'd10);
    check("sub_op2", operand2_out, 64'd3);
    drain_all("sub");

    // I-type OR with immediate; funct7b5 must not matter
    drive(2'b11, 3'b110, 1'b1, 1'b1, 64'd5, 64'd7, 64'hFF, OP_OR, 1'b0);
    tick();
    valid_in = 1'b0;
    check("ori_opcode", 64'(aluOpcode_out), 64'(OP_OR));
    check("ori_op2", operand2_out, 64'hFF);
    check("ori_illegal", 64'(illegal_out), 64'd0);
    drain_all("ori");

    // Illegal funct3 still handshakes
    drive(2'b10, 3'b001, 1'b0, 1'b0, 64'd1, 64'd2, 64'd0, OP_ADD, 1'b1);
    tick();
    valid_in = 1'b0;
    check("ill_valid", 64'(valid_out), 64'd1);
    check("ill_flag", 64'(illegal_out), 64'd1);
    check("ill_opcode", 64'(aluOpcode_out), 64'(OP_ADD));
    tick();
    check("ill_drained", 64'(valid_out), 64'd0);
    drain_all("ill");

    // Backpressure: A, B fill both slots, C waits upstream
    ready_in = 1'b0;
    drive(2'b10, 3'b111, 1'b0, 1'b0, 64'hA1, 64'hA2, 64'd0, OP_AND, 1'b0);
    tick();
    drive(2'b10, 3'b110, 1'b0, 1'b0, 64'hB1, 64'hB2, 64'd0, OP_OR, 1'b0);
    tick();
    check("bp_ready_after_b", 64'(ready_out), 64'd0);
    drive(2'b10, 3'b000, 1'b1, 1'b0, 64'hC1, 64'hC2, 64'd0, OP_SUB, 1'b0);
    tick();
    check("bp_c_held", 64'(last_accept), 64'd0);
    check("bp_hold_a", operand1_out, 64'hA1);
    ready_in = 1'b1;
    for (int n = 0; n < 10 && !last_accept; n++) tick();
    check("bp_c_accepted", 64'(last_accept), 64'd1);
    drain_all("bp");

    // Flush in state TWO with a new entry offered
    ready_in = 1'b0;
    drive(2'b01, 3'b000, 1'b0, 1'b0, 64'hD1, 64'hD2, 64'd0, OP_SUB, 1'b0);
    tick();
    drive(2'b01, 3'b000, 1'b0, 1'b0, 64'hE1, 64'hE2, 64'd0, OP_SUB, 1'b0);
    tick();
    check("fl_full", 64'(ready_out), 64'd0);
    drive(2'b00, 3'b000, 1'b0, 1'b0, 64'hF1, 64'hF2, 64'd0, OP_ADD, 1'b0);
    flush_in = 1'b1;
    tick();
    flush_in = 1'b0;
    valid_in = 1'b0;
    check("fl_valid", 64'(valid_out), 64'd0);
    check("fl_ready", 64'(ready_out), 64'd1);
    ready_in = 1'b1;
    tick();
    check("fl_no_capture", 64'(valid_out), 64'd0);

    // Reset in state TWO with downstream ready
    ready_in = 1'b0;
    drive(2'b10, 3'b111, 1'b0, 1'b0, 64'h11, 64'h22, 64'd0, OP_AND, 1'b0);
    tick();
    drive(2'b10, 3'b110, 1'b0, 1'b0, 64'h33, 64'h44, 64'd0, OP_OR, 1'b0);
    tick();
    valid_in = 1'b0;
    ready_in = 1'b1;
    reset_in = 1'b1;
    tick();
    reset_in = 1'b0;
    check_reset("rst2");
    check("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
